// File: rtl/boid_xcel_pkg.sv
// Shared types and helpers for the boid velocity accelerator.
// Holds the fix15 type (signed, 15 fraction bits), the speed-limit defaults,
// the speed-limiter FSM state encoding, and the saturating abs/multiply helpers.
package boid_xcel_pkg;

   typedef logic signed [31:0] fix15;

   localparam fix15        FIX15_ONE     = 32'sh0000_8000;
   localparam fix15        FIX15_MAX     = 32'sh7FFF_FFFF;
   localparam logic [31:0] DEF_MAX_SPEED = 32'h0003_0000;  // 6.0
   localparam logic [31:0] DEF_MIN_SPEED = 32'h0001_0000;  // 2.0
   localparam int          NUM_LANES     = 2;              // vx, vy

   typedef enum logic [2:0] {IDLE, MAG, DIV, SCALE, DONE} state_t;

   // |v| with the most negative value pinned to the most positive one.
   function automatic logic [31:0] abs_sat(input fix15 v);
      if (v == 32'sh8000_0000) return 32'h7FFF_FFFF;
      else if (v < 0)          return -v;
      else                     return v;
   endfunction

   // (a * b) >>> 15 on a full 64-bit signed product, saturated to 32 bits.
   function automatic fix15 fix15_mul_sat(input fix15 a, input fix15 b);
      logic signed [63:0] p;
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      p = p >>> 15;
      if (p > 64'sh0000_0000_7FFF_FFFF)      return 32'sh7FFF_FFFF;
      else if (p < 64'shFFFF_FFFF_8000_0000) return 32'sh8000_0000;
      else                                   return p[31:0];
   endfunction

endpackage

// File: rtl/boid_speed_limit_if.sv
// Handshake bundle for boid_speed_limit.
// Input stream:  in_valid/in_ready with vx_in/vy_in.
// Output stream: out_valid/out_ready with vx_out/vy_out/clamped.
// master = producer/consumer side (testbench), slave = the limiter.
interface boid_speed_limit_if;
   import boid_xcel_pkg::*;

   logic in_valid;
   logic in_ready;
   fix15 vx_in;
   fix15 vy_in;
   logic out_valid;
   logic out_ready;
   fix15 vx_out;
   fix15 vy_out;
   logic clamped;

   modport master (
      output in_valid, vx_in, vy_in, out_ready,
      input  in_ready, out_valid, vx_out, vy_out, clamped
   );

   modport slave (
      input  in_valid, vx_in, vy_in, out_ready,
      output in_ready, out_valid, vx_out, vy_out, clamped
   );

endinterface

// File: rtl/fix15_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, reset (async, active high); start loads dividend/divisor when
// idle; busy is high for exactly 32 cycles; done flags the final iteration
// cycle (quotient/overflow are valid from the following cycle on);
// overflow = quotient does not fit in 32 bits.
module fix15_div_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [46:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [31:0] quotient
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;   // low dividend bits shift out, quotient bits shift in
   logic [31:0] dvs_q;
   logic [5:0]  cnt_q;
   logic        busy_q;
   logic        ovf_q;
   logic [32:0] trial;
   logic        fits;

   assign trial = {rem_q, quo_q[31]};
   assign fits  = trial >= {1'b0, dvs_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (start && !busy_q) begin
         // The top 15 dividend bits seed the remainder; if they already reach
         // the divisor the quotient needs more than 32 bits.
         rem_q  <= {17'b0, dividend[46:32]};
         quo_q  <= dividend[31:0];
         dvs_q  <= divisor;
         ovf_q  <= {17'b0, dividend[46:32]} >= divisor;
         cnt_q  <= 6'd32;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q <= fits ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
         quo_q <= {quo_q[30:0], fits};
         cnt_q <= cnt_q - 6'd1;
         if (cnt_q == 6'd1) busy_q <= 1'b0;
      end
   end

   assign busy     = busy_q;
   assign done     = busy_q && (cnt_q == 6'd1);
   assign overflow = ovf_q;
   assign quotient = quo_q;

endmodule

// File: rtl/boid_speed_limit.sv
// Boid speed limiter: estimates |v| as max + min/2 of the component
// magnitudes and, if it lies outside (MIN_SPEED, MAX_SPEED), rescales the
// velocity by limit/speed. One velocity in flight at a time.
// Ports: clk, reset (async, active high), bus (slave side of
// boid_speed_limit_if: in_valid/in_ready/vx_in/vy_in,
// out_valid/out_ready/vx_out/vy_out/clamped).
module boid_speed_limit
   import boid_xcel_pkg::*;
#(
   parameter logic [31:0] MAX_SPEED = DEF_MAX_SPEED,
   parameter logic [31:0] MIN_SPEED = DEF_MIN_SPEED
) (
   input  logic              clk,
   input  logic              reset,
   boid_speed_limit_if.slave bus
);

   state_t state_q, state_d;

   logic [NUM_LANES-1:0][31:0] v_q;      // [0]=vx, [1]=vy
   logic [NUM_LANES-1:0][31:0] vout_q;
   logic [NUM_LANES-1:0][31:0] scaled;
   logic                       clamped_q;

   logic [31:0] ax, ay, vmax, vmin, speed, limit;
   logic        over, under;
   logic        accept, div_start, load_pass, load_scale;
   logic        div_busy, div_done, div_ovf;
   logic [31:0] quotient;
   fix15        factor;

   // Speed estimate from the registered inputs.
   assign ax    = abs_sat(v_q[0]);
   assign ay    = abs_sat(v_q[1]);
   assign vmax  = (ax >= ay) ? ax : ay;
   assign vmin  = (ax >= ay) ? ay : ax;
   assign speed = vmax + (vmin >> 1);  // <= 0xBFFF_FFFE, no wrap
   assign over  = speed > MAX_SPEED;
   assign under = (speed != 32'd0) && (speed < MIN_SPEED);
   assign limit = over ? MAX_SPEED : MIN_SPEED;

   fix15_div_seq u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend ({limit, 15'b0}),
      .divisor  (speed),
      .busy     (div_busy),
      .done     (div_done),
      .overflow (div_ovf),
      .quotient (quotient)
   );

   // The factor is a positive fix15, so anything with bit 31 set saturates.
   assign factor = (div_ovf || quotient[31]) ? FIX15_MAX : fix15'(quotient);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      assign scaled[i] = fix15_mul_sat(fix15'(v_q[i]), factor);
   end

   assign accept = bus.in_valid && (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      div_start  = 1'b0;
      load_pass  = 1'b0;
      load_scale = 1'b0;
      case (state_q)
         IDLE:  if (accept) state_d = MAG;
         MAG: begin
            if (over || under) begin
               div_start = !div_busy;
               state_d   = DIV;
            end else begin
               load_pass = 1'b1;
               state_d   = DONE;
            end
         end
         DIV:   if (div_done) state_d = SCALE;
         SCALE: begin
            load_scale = 1'b1;
            state_d    = DONE;
         end
         DONE:  if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         v_q       <= '0;
         vout_q    <= '0;
         clamped_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) v_q <= {bus.vy_in, bus.vx_in};
         if (load_pass) begin
            vout_q    <= v_q;
            clamped_q <= 1'b0;
         end else if (load_scale) begin
            vout_q    <= scaled;
            clamped_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.vx_out    = vout_q[0];
   assign bus.vy_out    = vout_q[1];
   assign bus.clamped   = clamped_q;

endmodule

// File: tb/tb_boid_speed_limit.sv
// Bench for boid_speed_limit: table of velocities with hand-derived results
// and latencies, scoreboard queue between driver and collector, plus
// backpressure and mid-divide reset sequences.
module tb_boid_speed_limit;
   import boid_xcel_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   boid_speed_limit_if bus();

   boid_speed_limit #(
      .MAX_SPEED (32'h0003_0000),
      .MIN_SPEED (32'h0001_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] vx;
      logic [31:0] vy;
      logic [31:0] ex;
      logic [31:0] ey;
      logic        ec;
      int          elat;   // cycles counted from the accept cycle
   } vec_t;

   vec_t sb[$];
   vec_t tbl[11];
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic send(input string name, input vec_t v);
      int n;
      bus.in_valid = 1'b1;
      bus.vx_in    = v.vx;
      bus.vy_in    = v.vy;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) chk({name, "_accept"}, 32'(bus.in_ready), 32'd1);
      sb.push_back(v);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic collect(input string name, input bit release_out);
      int   lat;
      vec_t e;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (sb.size() == 0) begin
         checks++;
         $display("FAIL %s_sb: scoreboard empty when output arrived", name);
         return;
      end
      e = sb.pop_front();
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_vx"},    bus.vx_out,         e.ex);
      chk({name, "_vy"},    bus.vy_out,         e.ey);
      chk({name, "_clamp"}, 32'(bus.clamped),   32'(e.ec));
      chk({name, "_lat"},   32'(lat),           32'(e.elat));
      if (release_out) begin
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1 bus.out_ready = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] hx, hy;
      logic        hc;
      bit          seen;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.vx_in     = '0;
      bus.vy_in     = '0;

      //         vx             vy             ex             ey             c     lat
      tbl[0]  = '{32'h0001_8000, 32'h0000_8000, 32'h0001_8000, 32'h0000_8000, 1'b0, 2};
      tbl[1]  = '{32'h0006_0000, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000, 1'b1, 35};
      tbl[2]  = '{32'hFFFF_8000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b1, 35};
      tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 2};
      tbl[4]  = '{32'h0003_0000, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000, 1'b0, 2};
      tbl[5]  = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 1'b0, 2};
      tbl[6]  = '{32'h0000_0000, 32'hFFFA_0000, 32'h0000_0000, 32'hFFFD_0000, 1'b1, 35};
      // speed 1 lsb: factor 2^31 saturates to 0x7FFF_FFFF -> 1*that>>>15
      tbl[7]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 35};
      // |0x8000_0000| -> 0x7FFF_FFFF, factor = 0x1_8000_0000/0x7FFF_FFFF = 3
      tbl[8]  = '{32'h8000_0000, 32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 1'b1, 35};
      tbl[9]  = '{32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 1'b0, 2};
      tbl[10] = '{32'h0004_0000, 32'h0004_0000, 32'h0002_0000, 32'h0002_0000, 1'b1, 35};

      // Reset state
      @(negedge clk);
      chk("rst_valid",   32'(bus.out_valid), 32'd0);
      chk("rst_vx",      bus.vx_out,         32'd0);
      chk("rst_vy",      bus.vy_out,         32'd0);
      chk("rst_clamped", 32'(bus.clamped),   32'd0);
      reset = 1'b0;
      #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Table vectors
      for (int i = 0; i < 11; i++) begin
         send($sformatf("v%0d", i), tbl[i]);
         collect($sformatf("v%0d", i), 1'b1);
      end

      // Backpressure: hold out_ready low in DONE, then a back-to-back input.
      send("bp1", tbl[0]);
      collect("bp1", 1'b0);
      hx = bus.vx_out;
      hy = bus.vy_out;
      hc = bus.clamped;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("bp_hold%0d_vx", k),    bus.vx_out,         hx);
         chk($sformatf("bp_hold%0d_vy", k),    bus.vy_out,         hy);
         chk($sformatf("bp_hold%0d_c", k),     32'(bus.clamped),   32'(hc));
         chk($sformatf("bp_hold%0d_rdy", k),   32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.vx_in     = tbl[1].vx;
      bus.vy_in     = tbl[1].vy;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk("bp_in_ready_next", 32'(bus.in_ready), 32'd1);
      chk("bp_valid_drop",    32'(bus.out_valid), 32'd0);
      send("bp2", tbl[1]);
      collect("bp2", 1'b1);

      // Reset during the divide (outputs hold 0x3_0000 from bp2 beforehand).
      send("mr", tbl[6]);
      seen = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mr_no_early_valid", 32'(seen), 32'd0);
      reset = 1'b1;
      #1;
      chk("mr_valid",   32'(bus.out_valid), 32'd0);
      chk("mr_vx",      bus.vx_out,         32'd0);
      chk("mr_vy",      bus.vy_out,         32'd0);
      chk("mr_clamped", 32'(bus.clamped),   32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
      send("post", tbl[10]);
      collect("post", 1'b1);
      send("post2", tbl[2]);
      collect("post2", 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/boid_speed_limit.md
BOID_SPEED_LIMIT -- requirements
Module: boid_speed_limit

Interface
REQ-001 SHALL have parameter MAX_SPEED, default 32'h0003_0000 (6.0 fix15); upper speed limit.
REQ-002 SHALL have parameter MIN_SPEED, default 32'h0001_0000 (2.0 fix15); lower speed limit.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  vx_in/vy_in hold a velocity to process.
REQ-006 SHALL have port in_ready  output  1  block can accept a velocity.
REQ-007 SHALL have ports vx_in and vy_in  input  32 each  signed fix15 velocity components.
REQ-008 SHALL have port out_valid  output  1  vx_out/vy_out/clamped are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have ports vx_out and vy_out  output  32 each  signed fix15 limited velocity.
REQ-011 SHALL have port clamped  output  1  the result was rescaled.

Function
REQ-012 SHALL implement FSM states IDLE, MAG, DIV, SCALE, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept occurs when in_valid and in_ready are both high at a clock edge; IDLE->MAG; inputs are registered.
REQ-014 In MAG, SHALL compute speed = max(|vx|,|vy|) + (min(|vx|,|vy|) >>> 1), with the comparison made on absolute values and |0x8000_0000| saturated to 0x7FFF_FFFF.
REQ-015 In MAG, if speed > MAX_SPEED, SHALL select limit = MAX_SPEED and go to DIV.
REQ-016 In MAG, if 0 < speed < MIN_SPEED, SHALL select limit = MIN_SPEED and go to DIV.
REQ-017 In MAG, in all other cases (including speed == 0, speed == MAX_SPEED, speed == MIN_SPEED), SHALL go to DONE with outputs equal to the inputs and clamped = 0.
REQ-018 In DIV, SHALL compute factor = (limit << 15) / speed with an unsigned restoring divider, 1 quotient bit per cycle, exactly 32 cycles.
REQ-019 If the quotient overflows, SHALL set factor to 32'h7FFF_FFFF.
REQ-020 In SCALE (1 cycle), SHALL compute v_out = (v * factor) >>> 15 per component on a 64-bit signed product, saturate to the signed 32-bit range, and set clamped = 1.
REQ-021 Latency from accept edge to out_valid high SHALL be 2 cycles on pass-through and 35 cycles on the clamp path, with no data-dependent variation.
REQ-022 In DONE, SHALL hold out_valid high and vx_out/vy_out/clamped stable until out_ready is high at an edge, then go to IDLE.
REQ-023 A held out_ready SHALL be ignored outside DONE; out_valid SHALL be low in every state other than DONE.
REQ-024 Throughput SHALL be one velocity at a time, with no overlap between consecutive transactions.

Reset
REQ-025 While reset is high, SHALL force state to IDLE and drive out_valid = 0, vx_out = 0, vy_out = 0, clamped = 0, with all internal registers cleared.
REQ-026 Reset in any state, including mid-DIV, SHALL abort the transaction without producing output; in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-027 Package boid_xcel_pkg SHALL hold the fix15 typedef (logic signed [31:0]), FIX15_ONE = 32'h0000_8000, the FSM state enum, and the MAX_SPEED/MIN_SPEED default constants.
REQ-028 The divider SHALL be a separate sub-module fix15_div_seq with start/busy/done signals, a 32-cycle fixed latency, and asynchronous reset.
REQ-029 Scaling multiplies SHALL use the existing fix15_mul helper extended with saturation, or an equivalent inline 64-bit product.

Verification
REQ-030 Pass-through: vx=0x0001_8000 (3.0), vy=0x0000_8000 (1.0) -> speed 3.5; out_valid 2 cycles after accept; outputs equal inputs; clamped=0.
REQ-031 Over-limit: vx=0x0006_0000 (12.0), vy=0 -> factor 0x4000; vx_out=0x0003_0000, vy_out=0, clamped=1; out_valid 35 cycles after accept.
REQ-032 Under-limit: vx=0xFFFF_8000 (-1.0), vy=0 -> factor 0x1_0000; vx_out=0xFFFF_0000 (-2.0), vy_out=0, clamped=1.
REQ-033 Zero vector: vx=vy=0 -> outputs 0, clamped=0, latency 2, no DIV entry.
REQ-034 Backpressure: out_ready low for 5 cycles in DONE -> outputs stable and in_ready low; when out_ready rises, next cycle in_ready=1 and a back-to-back input is accepted.
REQ-035 Reset at DIV cycle 10 -> out_valid, vx_out, vy_out, clamped all 0 immediately; in_ready=1 after release; the next transaction gives correct results.
